// File: rtl/shifter_arbiter.sv
// shifter_arbiter: two-requester front end for one shared 32-bit barrel shifter.
// Define SHIFT_ARB_RR_EN for round-robin contention; default is fixed priority to requester 0.
module shifter_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_T,
    input  logic [4:0]  req0_shamt,
    input  logic [4:0]  req0_type,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_T,
    input  logic [4:0]  req1_shamt,
    input  logic [4:0]  req1_type,
    output logic        req1_ready,
    output logic [31:0] sh_T,
    output logic [4:0]  sh_shamt,
    output logic [4:0]  sh_type,
    input  logic [31:0] sh_Y,
    input  logic        sh_C,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_Y,
    output logic        rsp_C,
    output logic        rsp_err,
    input  logic        rsp_ready
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t      state;
    logic [31:0] op_T;
    logic [4:0]  op_shamt;
    logic [4:0]  op_type;
    logic        op_id;
    logic        prio1;
    logic        accept;
    logic        gnt0;
    logic        gnt1;
    logic        legal;

`ifdef SHIFT_ARB_RR_EN
    logic ptr;
    assign prio1 = ptr;
`else
    assign prio1 = 1'b0;
`endif

    // Grants are only offered while idle and out of reset.
    assign accept     = reset && (state == IDLE);
    assign gnt1       = accept && req1_valid && (!req0_valid || prio1);
    assign gnt0       = accept && req0_valid && !gnt1;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    assign sh_T     = op_T;
    assign sh_shamt = op_shamt;
    assign sh_type  = op_type;

    assign legal = (op_type == 5'h0C) ||
                   (op_type == 5'h0D) ||
                   (op_type == 5'h0E);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op_T      <= '0;
            op_shamt  <= '0;
            op_type   <= '0;
            op_id     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_Y     <= '0;
            rsp_C     <= 1'b0;
            rsp_err   <= 1'b0;
`ifdef SHIFT_ARB_RR_EN
            ptr       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        op_T     <= gnt1 ? req1_T : req0_T;
                        op_shamt <= gnt1 ? req1_shamt : req0_shamt;
                        op_type  <= gnt1 ? req1_type : req0_type;
                        op_id    <= gnt1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Illegal types bypass the shifter and echo the operand.
                    rsp_Y     <= legal ? sh_Y : op_T;
                    rsp_C     <= legal && sh_C;
                    rsp_err   <= !legal;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
`ifdef SHIFT_ARB_RR_EN
                        ptr       <= ~ptr;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shifter_arbiter.sv
// tb_shifter_arbiter: random + directed scoreboard bench for shifter_arbiter.
// Compile with SHIFT_ARB_RR_EN to match a round-robin build of the design.
module tb_shifter_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 1'b0;
    logic [31:0] req0_T = '0;
    logic [4:0]  req0_shamt = '0;
    logic [4:0]  req0_type = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [31:0] req1_T = '0;
    logic [4:0]  req1_shamt = '0;
    logic [4:0]  req1_type = '0;
    logic        req1_ready;
    logic [31:0] sh_T;
    logic [4:0]  sh_shamt;
    logic [4:0]  sh_type;
    logic [31:0] sh_Y;
    logic        sh_C;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_Y;
    logic        rsp_C;
    logic        rsp_err;
    logic        rsp_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic        id;
        logic [31:0] y;
        logic        c;
        logic        e;
    } exp_t;

    exp_t q[$];

    shifter_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_T(req0_T),
        .req0_shamt(req0_shamt), .req0_type(req0_type),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_T(req1_T),
        .req1_shamt(req1_shamt), .req1_type(req1_type),
        .req1_ready(req1_ready),
        .sh_T(sh_T), .sh_shamt(sh_shamt), .sh_type(sh_type),
        .sh_Y(sh_Y), .sh_C(sh_C),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_Y(rsp_Y), .rsp_C(rsp_C), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Returns {err, carry, result}; carry is the last bit shifted out.
    function automatic logic [33:0] ref_shift(input logic [31:0] t,
                                              input logic [4:0] s,
                                              input logic [4:0] ty);
        logic [31:0] y;
        logic        c;
        logic        e;
        y = t;
        c = 1'b0;
        e = 1'b0;
        case (ty)
            5'h0C: begin
                y = t << s;
                c = (s == 0) ? 1'b0 : t[32 - int'(s)];
            end
            5'h0D: begin
                y = t >> s;
                c = (s == 0) ? 1'b0 : t[int'(s) - 1];
            end
            5'h0E: begin
                y = 32'($signed(t) >>> s);
                c = (s == 0) ? 1'b0 : t[int'(s) - 1];
            end
            default: e = 1'b1;
        endcase
        return {e, c, y};
    endfunction

    // External shifter: drives junk for illegal types so sampling it shows.
    logic [33:0] shres;
    assign shres = ref_shift(sh_T, sh_shamt, sh_type);
    assign sh_Y  = shres[33] ? ~sh_T : shres[31:0];
    assign sh_C  = shres[33] ? 1'b1 : shres[32];

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Grant tracker: predicts the winner and pushes the expected response.
    logic busy = 1'b0;
    logic ptr = 1'b0;
    int   gcyc = 0;

    always @(negedge clk) begin
        logic        w;
        logic [33:0] r;
        exp_t        e;
        if (!reset) begin
            busy <= 1'b0;
            ptr  <= 1'b0;
        end else if (busy) begin
            chk(!req0_ready && !req1_ready, "ready_busy",
                {req0_ready, req1_ready}, 0);
            if (cyc >= gcyc + 2 && rsp_ready) begin
                busy <= 1'b0;
`ifdef SHIFT_ARB_RR_EN
                ptr  <= ~ptr;
`endif
            end
        end else if (req0_valid || req1_valid) begin
            w = (req0_valid && req1_valid) ? ptr : req1_valid;
            chk(req0_ready == !w && req1_ready == w, "grant",
                {req0_ready, req1_ready}, {!w, w});
            r = w ? ref_shift(req1_T, req1_shamt, req1_type)
                  : ref_shift(req0_T, req0_shamt, req0_type);
            e.cyc = cyc;
            e.id  = w;
            e.e   = r[33];
            e.c   = r[33] ? 1'b0 : r[32];
            e.y   = r[33] ? (w ? req1_T : req0_T) : r[31:0];
            q.push_back(e);
            busy <= 1'b1;
            gcyc <= cyc;
        end else begin
            chk(!req0_ready && !req1_ready, "ready_idle",
                {req0_ready, req1_ready}, 0);
        end
    end

    // Response monitor: pops and compares on each handshake.
    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
            chk(!rsp_valid && rsp_Y == 0 && !rsp_C && !rsp_err &&
                !rsp_id && !req0_ready && !req1_ready &&
                sh_T == 0 && sh_shamt == 0 && sh_type == 0,
                "reset_state",
                {rsp_valid, rsp_id, rsp_err, rsp_C, rsp_Y}, 0);
        end else if (q.size() == 0 || cyc < q[0].cyc + 2) begin
            chk(!rsp_valid, "rsp_quiet", rsp_valid, 0);
        end else begin
            chk(rsp_valid && rsp_id == q[0].id && rsp_err == q[0].e &&
                rsp_C == q[0].c && rsp_Y == q[0].y, "rsp_data",
                {rsp_valid, rsp_id, rsp_err, rsp_C, rsp_Y},
                {1'b1, q[0].id, q[0].e, q[0].c, q[0].y});
            if (rsp_ready) void'(q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit id, input logic [31:0] t,
                           input logic [4:0] s, input logic [4:0] ty);
        if (id) begin
            req1_valid = 1'b1; req1_T = t;
            req1_shamt = s;    req1_type = ty;
        end else begin
            req0_valid = 1'b1; req0_T = t;
            req0_shamt = s;    req0_type = ty;
        end
    endtask

    task automatic one(input bit id, input logic [31:0] t,
                       input logic [4:0] s, input logic [4:0] ty);
        set_req(id, t, s, ty);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (4) tick();
    endtask

    function automatic logic [4:0] rnd_type();
        if ($urandom % 5 == 0) return 5'($urandom);
        return 5'h0C + 5'($urandom % 3);
    endfunction

    task automatic rnd_req(input bit id, input bit v);
        set_req(id, $urandom, 5'($urandom), rnd_type());
        if (id) req1_valid = v;
        else    req0_valid = v;
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b1;
        rsp_ready = 1'b1;
        tick();

        one(0, 32'h0000_0001, 5'd4, 5'h0C);
        one(1, 32'h8000_0000, 5'd4, 5'h0E);
        one(0, 32'hDEAD_BEEF, 5'd3, 5'h1F);
        one(1, 32'h1234_5678, 5'd0, 5'h0D);
        one(0, 32'h8000_0001, 5'd31, 5'h0C);

        // Stall in RESP while requester 1 waits.
        rsp_ready = 1'b0;
        set_req(0, 32'hF0F0_1234, 5'd8, 5'h0D);
        tick();
        req0_valid = 1'b0;
        set_req(1, 32'hCAFE_0001, 5'd1, 5'h0E);
        repeat (7) tick();
        rsp_ready = 1'b1;
        repeat (2) tick();
        req1_valid = 1'b0;
        repeat (4) tick();

        // Reset during ISSUE, then contention must favour requester 0.
        set_req(1, 32'h0000_00FF, 5'd2, 5'h0C);
        tick();
        req1_valid = 1'b0;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 13; i++) begin
            rnd_req(0, 1'b1);
            rnd_req(1, 1'b1);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (4) tick();

        // Reset during a stalled RESP.
        rsp_ready = 1'b0;
        set_req(0, 32'h1111_2222, 5'd5, 5'h0C);
        tick();
        req0_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 400; i++) begin
            rnd_req(0, ($urandom % 3) != 0);
            rnd_req(1, ($urandom % 3) != 0);
            if (i % 50 < 6) rsp_ready = 1'b0;
            else rsp_ready = ($urandom % 4) != 0;
            tick();
        end

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (6) tick();
        chk(q.size() == 0, "drain", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shifter_arbiter.md
SHIFTER_ARBITER -- requirements
Module: shifter_arbiter

Interface
REQ-001 Parameters: none; all widths are fixed (32-bit data, 5-bit shamt, 5-bit type).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_T  input  32  requester N data operand.
REQ-006 reqN_shamt  input  5  requester N shift amount.
REQ-007 reqN_type  input  5  requester N shift type (5'h0C SLL, 5'h0D SRL, 5'h0E SRA).
REQ-008 reqN_ready  output  1  requester N operation accepted this cycle.
REQ-009 sh_T / sh_shamt / sh_type  output  32/5/5  operands driven to the shared 32-bit barrel shifter.
REQ-010 sh_Y / sh_C  input  32/1  combinational shifter result and carry.
REQ-011 rsp_valid  output  1  result available.
REQ-012 rsp_id  output  1  index of the requester that owns the result.
REQ-013 rsp_Y / rsp_C  output  32/1  registered shift result and carry.
REQ-014 rsp_err  output  1  request carried an illegal type.
REQ-015 rsp_ready  input  1  consumer accepts the result.

Function
REQ-016 FSM states: IDLE, ISSUE, RESP; exactly one state active.
REQ-017 IDLE: if any reqN_valid, pick winner per REQ-022, assert its reqN_ready combinationally for that cycle only, latch T/shamt/type/id into operand registers, go to ISSUE; else stay.
REQ-018 reqN_ready is 0 in ISSUE and RESP and for the losing requester; at most one ready high per cycle.
REQ-019 ISSUE: operand registers drive sh_T/sh_shamt/sh_type; at clock edge capture sh_Y/sh_C into rsp_Y/rsp_C, go to RESP.
REQ-020 sh_* outputs hold operand registers in all states (stable between operations, no glitching from request ports).
REQ-021 RESP: rsp_valid=1, rsp_Y/rsp_C/rsp_id/rsp_err held stable until rsp_ready=1; on rsp_ready go to IDLE, rsp_valid drops next cycle.
REQ-022 Arbitration: single valid wins; both valid resolved per Configuration section.
REQ-023 Latency: acceptance cycle to rsp_valid high = 2 clocks; throughput one operation per 3 clocks at best (rsp_ready held high).
REQ-024 Illegal type (not 0C/0D/0E): accepted normally, shifter not sampled; rsp_Y=latched T, rsp_C=0, rsp_err=1.
REQ-025 Legal type: rsp_err=0.
REQ-026 shamt=0 passes through shifter unchanged; controller adds no special case.
REQ-027 Request deasserting while not granted: no effect, no state recorded.

Reset
REQ-028 reset low asynchronously forces IDLE, rsp_valid=0, rsp_id=0, rsp_Y=0, rsp_C=0, rsp_err=0, operand registers 0, priority pointer to requester 0.
REQ-029 reset mid-ISSUE or mid-RESP discards the in-flight operation; no response is issued after release.
REQ-030 reqN_ready=0 while reset is asserted.

Configuration
REQ-031 Macro SHIFT_ARB_RR_EN defined: round-robin; pointer toggles to the other requester after each completed response (RESP exit); on contention the pointed-to requester wins.
REQ-032 SHIFT_ARB_RR_EN undefined: fixed priority, requester 0 always wins on contention; no pointer register.

Verification
REQ-033 req0 only, T=32'h0000_0001, shamt=4, type=0C, rsp_ready=1 -> req0_ready 1 cycle, rsp_valid 2 clocks later, rsp_Y=32'h0000_0010, rsp_C=0, rsp_id=0.
REQ-034 req1 only, T=32'h8000_0000, shamt=4, type=0E -> rsp_Y=32'hF800_0000, rsp_id=1, rsp_err=0.
REQ-035 Both valid continuously, rsp_ready=1, RR_EN defined -> grants alternate 0,1,0,1; RR_EN undefined -> req0 granted every time.
REQ-036 Type 5'h1F, T=32'hDEAD_BEEF -> rsp_Y=32'hDEAD_BEEF, rsp_C=0, rsp_err=1.
REQ-037 rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, no reqN_ready asserted, exit one cycle after rsp_ready=1.
REQ-038 reset pulsed low during ISSUE -> rsp_valid stays 0, all outputs zero, next request served normally with requester 0 priority.
